pueo_beam_thresh_scaler: RTL
============================

Name: pueo_beam_thresh_scaler

Overview:
- Sits directly downstream of the dual-beam power-sum trigger stage, in the same clock domain.
- Consumes the 2-bit per-beam trigger output and counts triggers per beam over a fixed gate, producing scaler readouts.
- Also sequences threshold loads back into the beam stage's thresh/thresh_ce/update inputs from register-written shadow thresholds.
- Closes the loop for software threshold servoing.

Parameters:
- GATE_CYCLES, 375000, clocks per scaler gate (1 ms at 375 MHz); legal range 2 to 2^24.
- CNT_BITS, 24, width of each per-beam trigger counter.
- THRESH_BITS, 18, threshold width; fixed to match the beam DSP operand.

Ports:
- clk_i  in  1  beam-domain clock (all logic on rising edge).
- rst_i  in  1  synchronous, active-high reset.
- trigger_i  in  2  per-beam trigger from beam stage; bit0 = beam A, bit1 = beam B.
- thr_wr_i  in  1  single-cycle write strobe for a shadow threshold.
- thr_sel_i  in  1  shadow select: 0 = beam A, 1 = beam B.
- thr_dat_i  in  THRESH_BITS  threshold magnitude, unsigned.
- thresh_o  out  THRESH_BITS  to beam stage thresh_i.
- thresh_ce_o  out  2  to beam stage thresh_ce_i.
- update_o  out  1  to beam stage update_i.
- load_busy_o  out  1  high while any threshold load is pending or in progress.
- count_o  out  2*CNT_BITS  {beamB, beamA} latched scaler counts.
- count_valid_o  out  1  one-cycle pulse when count_o is updated.

Behaviour:
- Reset: all of the following are 0: outputs, shadows, pending flags, counters, gate counter. FSM goes to IDLE.
- Shadow write: on thr_wr_i, shadow[thr_sel_i] <= thr_dat_i and pending[thr_sel_i] <= 1. The write takes effect the same cycle pending is cleared, and the write wins.
- Two's-complement encoding: the beam stage computes sum + thresh. thresh_o therefore carries (2^18 - shadow) mod 2^18, so shadow 0 loads 0.
- Loader FSM states: IDLE, LOAD_A, LOAD_B, UPDATE.
  - IDLE: if pending[0], go to LOAD_A; else if pending[1], go to LOAD_B; else stay.
  - LOAD_A: thresh_o = -shadowA; thresh_ce_o = 01; clear pending[0]. Next is LOAD_B if pending[1], else UPDATE.
  - LOAD_B: thresh_o = -shadowB; thresh_ce_o = 10; clear pending[1]. Next is UPDATE.
  - UPDATE: update_o = 1 for exactly one cycle. Next is IDLE.
- Loader outputs are registered. thresh_ce_o is 00 and update_o is 0 outside the states above. thresh_o holds its last value.
- A write arriving during LOAD_x or UPDATE re-sets pending. That causes a fresh sequence after returning to IDLE, so no write is ever lost.
- load_busy_o = (pending != 0) or (state != IDLE).
- Latency: a write to an idle block gives thresh_ce_o at cycle +2 and update_o at cycle +3 (single beam); for both beams, +2 and +4.
- Gate counter: counts 0 to GATE_CYCLES-1, then wraps.
- On the terminal cycle:
  - count_o <= counters plus that cycle's trigger_i.
  - count_valid_o pulses.
  - Both counters restart at 0.
  - A trigger in the terminal cycle belongs to the ending gate.
- Counters saturate at 2^CNT_BITS-1 and do not wrap.
- Both beams are counted independently; simultaneous triggers each increment their own counter.
- Reset mid-gate discards partial counts; count_o returns to 0 and the next valid pulse comes GATE_CYCLES cycles after rst_i deasserts.
- Reset mid-load abandons the sequence; no update_o is emitted.

Decomposition:
- Shared package pueo_beam_pkg holds:
  - THRESH_BITS = 18
  - NBEAMS = 2
  - typedef thresh_t (logic [17:0])
  - enum loader_state_t {IDLE, LOAD_A, LOAD_B, UPDATE}
- One sub-module: pueo_sat_counter (CNT_BITS parameter; inc, clr, and clr-with-inc inputs; saturating). It is instantiated twice.

Test Plan:
- Write A=100 with the block idle. Cycle+2: thresh_ce_o=01 and thresh_o=0x3FF9C. Cycle+3: update_o=1. load_busy_o low at +4.
- Write A=5 and B=7 on consecutive cycles. Required: LOAD_A then LOAD_B with thresh_o=0x3FFFB then 0x3FFF9, exactly one update_o pulse after both.
- Write B=9 during an UPDATE cycle. Required: a second sequence loads 0x3FFF7 with ce=10, followed by a second update_o.
- GATE_CYCLES=16; trigger_i=11 on 5 cycles and 01 on 3 cycles, one of them on the terminal cycle. Required: count_o A=8, B=5, one valid pulse, next gate starts at 0.
- CNT_BITS=4, GATE_CYCLES=32, trigger_i=01 constantly. Required: A=15 (saturated), B=0.
- Assert rst_i mid-LOAD_B and mid-gate. Required: no update_o, count_o=0, next count_valid_o exactly GATE_CYCLES cycles after release.

Source files
------------

// File: rtl/pueo_beam_pkg.sv
// Shared types and constants for the beam trigger stage and its threshold/scaler companion.
package pueo_beam_pkg;

    localparam int unsigned THRESH_BITS = 18;
    localparam int unsigned NBEAMS      = 2;

    typedef logic [THRESH_BITS-1:0] thresh_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_A = 2'd1,
        LOAD_B = 2'd2,
        UPDATE = 2'd3
    } loader_state_t;

    // The beam stage adds the threshold to its power sum, so it wants the negated magnitude.
    function automatic thresh_t neg_thresh(input thresh_t mag);
        return thresh_t'(~mag + thresh_t'(1));
    endfunction

endpackage

// File: rtl/pueo_sat_counter.sv
// Saturating event counter with synchronous clear; also exposes count-plus-this-cycle's-event.
module pueo_sat_counter #(
    parameter int unsigned CNT_BITS = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    output logic [CNT_BITS-1:0] total_c
);

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic [CNT_BITS-1:0] count;

    // Count plus the current event, pinned at full scale so it never wraps.
    assign total_c = (inc && (count != CNT_MAX)) ? count + CNT_BITS'(1) : count;

    // Clear drops this cycle's event too: the caller has already latched total_c.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else begin
            count <= total_c;
        end
    end

endmodule

// File: rtl/pueo_beam_thresh_scaler.sv
// Per-beam trigger scalers over a fixed gate, plus the shadow-threshold load sequencer for the beam stage.
module pueo_beam_thresh_scaler
    import pueo_beam_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = 375000,
    parameter int unsigned CNT_BITS    = 24
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NBEAMS-1:0]        trigger_i,
    input  logic                     thr_wr_i,
    input  logic                     thr_sel_i,
    input  logic [THRESH_BITS-1:0]   thr_dat_i,
    output logic [THRESH_BITS-1:0]   thresh_o,
    output logic [NBEAMS-1:0]        thresh_ce_o,
    output logic                     update_o,
    output logic                     load_busy_o,
    output logic [2*CNT_BITS-1:0]    count_o,
    output logic                     count_valid_o
);

    localparam int unsigned GATE_BITS = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GATE_BITS-1:0] GATE_LAST = GATE_BITS'(GATE_CYCLES - 1);

    loader_state_t       state;
    logic [NBEAMS-1:0]   pending;
    thresh_t             shadow_a;
    thresh_t             shadow_b;

    logic [GATE_BITS-1:0] gate_cnt;
    logic                 gate_end_c;
    logic [CNT_BITS-1:0]  total_a_c;
    logic [CNT_BITS-1:0]  total_b_c;

    // Shadow registers and load sequencer; outputs are set on entry to each load state.
    // Pending is cleared when its load is launched, and a same-cycle write re-arms it
    // so a value that arrives while a load is underway is loaded by a later sequence.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            pending     <= '0;
            shadow_a    <= '0;
            shadow_b    <= '0;
            thresh_o    <= '0;
            thresh_ce_o <= '0;
            update_o    <= 1'b0;
        end else begin
            thresh_ce_o <= '0;
            update_o    <= 1'b0;
            case (state)
                IDLE: begin
                    if (pending[0]) begin
                        state       <= LOAD_A;
                        thresh_o    <= neg_thresh(shadow_a);
                        thresh_ce_o <= 2'b01;
                        pending[0]  <= 1'b0;
                    end else if (pending[1]) begin
                        state       <= LOAD_B;
                        thresh_o    <= neg_thresh(shadow_b);
                        thresh_ce_o <= 2'b10;
                        pending[1]  <= 1'b0;
                    end
                end
                LOAD_A: begin
                    if (pending[1]) begin
                        state       <= LOAD_B;
                        thresh_o    <= neg_thresh(shadow_b);
                        thresh_ce_o <= 2'b10;
                        pending[1]  <= 1'b0;
                    end else begin
                        state    <= UPDATE;
                        update_o <= 1'b1;
                    end
                end
                LOAD_B: begin
                    state    <= UPDATE;
                    update_o <= 1'b1;
                end
                UPDATE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
            if (thr_wr_i) begin
                pending[thr_sel_i] <= 1'b1;
                if (thr_sel_i) begin
                    shadow_b <= thr_dat_i;
                end else begin
                    shadow_a <= thr_dat_i;
                end
            end
        end
    end

    assign load_busy_o = (pending != '0) || (state != IDLE);

    // Gate timebase: free-running 0..GATE_CYCLES-1.
    assign gate_end_c = (gate_cnt == GATE_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i || gate_end_c) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + GATE_BITS'(1);
        end
    end

    pueo_sat_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_cnt_a (
        .clk     (clk_i),
        .rst     (rst_i),
        .inc     (trigger_i[0]),
        .clr     (gate_end_c),
        .total_c (total_a_c)
    );

    pueo_sat_counter #(
        .CNT_BITS (CNT_BITS)
    ) u_cnt_b (
        .clk     (clk_i),
        .rst     (rst_i),
        .inc     (trigger_i[1]),
        .clr     (gate_end_c),
        .total_c (total_b_c)
    );

    // Latch the gate totals, including the terminal cycle's triggers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_o       <= '0;
            count_valid_o <= 1'b0;
        end else begin
            count_valid_o <= gate_end_c;
            if (gate_end_c) begin
                count_o <= {total_b_c, total_a_c};
            end
        end
    end

endmodule
